// File: rtl/seven_segment_mux_if.sv
// Pin bundle between a status-register block (master) and the seven-segment scanner (slave).
interface seven_segment_mux_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  enable;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame_tick;

  modport master (
    output load, value_in, dp_in, enable,
    input  seg, dp, an, pending, frame_tick
  );

  modport slave (
    input  load, value_in, dp_in, enable,
    output seg, dp, an, pending, frame_tick
  );
endinterface

// File: rtl/seven_segment_mux.sv
// Time-multiplexed hex driver for DIGITS seven-segment digits with tear-free frame updates.
// Optional build macro SEVSEG_LZB_EN enables leading-zero blanking.
module seven_segment_mux #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEADTIME       = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_segment_mux_if.slave  bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     DEAD_END  = PW'(DEADTIME);
  localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF    = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow_val, disp_val;
  logic [DIGITS-1:0]     shadow_dp, disp_dp;
  logic                  pending_q;

  logic                  slot_end, frame_wrap, lit;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [6:0]            cur_seg;
  logic [DIGITS-1:0]     an_sel;

  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [DIGITS-1:0]     an_p1;
  logic                  tick_p1;

  // Positive-logic glyph: bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;
      4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;
      default: glyph = 7'h47;
    endcase
  endfunction

`ifdef SEVSEG_LZB_EN
  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  function automatic logic lzb_blank(input logic [4*DIGITS-1:0] val, input logic [IW-1:0] k);
    logic zero_above;
    zero_above = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if ((IW'(j) >= k) && (val[4*j +: 4] != 4'h0)) zero_above = 1'b0;
    return zero_above && (k != '0);
  endfunction
`endif

  assign slot_end   = (pcnt == PCNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign lit        = bus.enable && (pcnt >= DEAD_END);

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    an_sel  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = disp_val[4*k +: 4];
        cur_dp    = disp_dp[k];
        an_sel[k] = lit;
      end
    end
  end

  always_comb begin
    cur_seg = glyph(cur_nib);
`ifdef SEVSEG_LZB_EN
    if (lzb_blank(disp_val, idx)) cur_seg = 7'h00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load coinciding with the wrap bypasses the shadow so it lands in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending_q  <= 1'b0;
    end else if (bus.load && frame_wrap) begin
      disp_val  <= bus.value_in;
      disp_dp   <= bus.dp_in;
      pending_q <= 1'b0;
    end else begin
      if (frame_wrap && pending_q) begin
        disp_val  <= shadow_val;
        disp_dp   <= shadow_dp;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        shadow_val <= bus.value_in;
        shadow_dp  <= bus.dp_in;
        pending_q  <= 1'b1;
      end
    end
  end

  // Stage p1: output registers, polarity applied here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1  <= SEG_OFF;
      dp_p1   <= DP_OFF;
      an_p1   <= AN_OFF;
      tick_p1 <= 1'b0;
    end else begin
      seg_p1  <= cur_seg ^ SEG_OFF;
      dp_p1   <= cur_dp ^ DP_OFF;
      an_p1   <= an_sel ^ AN_OFF;
      tick_p1 <= frame_wrap;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.an         = an_p1;
  assign bus.frame_tick = tick_p1;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: a cycle-level reference model queues expected pins, a monitor compares.
`timescale 1ns/1ps
module tb_seven_segment_mux;
  localparam int DIG   = 4;
  localparam int SD    = 4;
  localparam int DT    = 1;
  localparam int FRAME = DIG * SD;

  typedef struct packed {
    logic [6:0]     seg;
    logic           dp;
    logic [DIG-1:0] an;
    logic           tick;
    logic           pend;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_segment_mux_if #(.DIGITS(DIG)) bus();

  seven_segment_mux #(
    .DIGITS(DIG), .SCAN_DIV(SD), .DEADTIME(DT), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  // Reference model: cycle count since reset release plus per-digit arrays.
  int t;
  int sh_nib[DIG];
  int ds_nib[DIG];
  bit sh_dp[DIG];
  bit ds_dp[DIG];
  bit m_pend;
  bit en_cur;

  string glyph_txt[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] lit_segs(input int v);
    string s;
    logic [6:0] b;
    int p;
    s = glyph_txt[v];
    b = '0;
    for (int i = 0; i < s.len(); i++) begin
      p = int'(s[i]) - int'(8'h61);
      b[6 - p] = 1'b1;
    end
    return b;
  endfunction

  function automatic obs_t pins();
    return {bus.seg, bus.dp, bus.an, bus.frame_tick, bus.pending};
  endfunction

  task automatic model_reset();
    t = 0;
    m_pend = 1'b0;
    for (int k = 0; k < DIG; k++) begin
      sh_nib[k] = 0; ds_nib[k] = 0; sh_dp[k] = 1'b0; ds_dp[k] = 1'b0;
    end
  endtask

  // Apply inputs for the coming edge and queue the pins expected just after it.
  task automatic drive_cycle(input bit ld, input logic [4*DIG-1:0] val, input logic [DIG-1:0] dpv);
    int p, i;
    bit wrap, blank;
    obs_t e;
    bus.load = ld; bus.value_in = val; bus.dp_in = dpv; bus.enable = en_cur;
    p = t % SD;
    i = (t / SD) % DIG;
    wrap = (p == SD - 1) && (i == DIG - 1);
    e.an = '1;
    if (en_cur && p >= DT) e.an[i] = 1'b0;
    blank = 1'b0;
`ifdef SEVSEG_LZB_EN
    if (i > 0) begin
      blank = 1'b1;
      for (int j = i; j < DIG; j++) if (ds_nib[j] != 0) blank = 1'b0;
    end
`endif
    e.seg  = blank ? 7'h7F : ~lit_segs(ds_nib[i]);
    e.dp   = ~ds_dp[i];
    e.tick = wrap;
    if (ld && wrap) begin
      for (int k = 0; k < DIG; k++) begin ds_nib[k] = int'(val[4*k +: 4]); ds_dp[k] = dpv[k]; end
      m_pend = 1'b0;
    end else begin
      if (wrap && m_pend) begin
        for (int k = 0; k < DIG; k++) begin ds_nib[k] = sh_nib[k]; ds_dp[k] = sh_dp[k]; end
        m_pend = 1'b0;
      end
      if (ld) begin
        for (int k = 0; k < DIG; k++) begin sh_nib[k] = int'(val[4*k +: 4]); sh_dp[k] = dpv[k]; end
        m_pend = 1'b1;
      end
    end
    e.pend = m_pend;
    exp_q.push_back(e);
    t++;
  endtask

  task automatic step(input bit ld, input logic [4*DIG-1:0] val, input logic [DIG-1:0] dpv);
    @(negedge clk);
    drive_cycle(ld, val, dpv);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0);
  endtask

  task automatic run_to(input int ph);
    int guard;
    guard = 0;
    while (((t % FRAME) != ph) && (guard < FRAME)) begin
      step(1'b0, '0, '0);
      guard++;
    end
  endtask

  task automatic check_reset(input string tag);
    obs_t a, r;
    a = pins();
    r = {7'h7F, 1'b1, {DIG{1'b1}}, 1'b0, 1'b0};
    n_cmp++;
    if (a !== r) begin
      n_bad++;
      $display("FAIL reset_%s actual=%b required=%b", tag, a, r);
    end
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      en_cur = ($urandom_range(9) != 0);
      if ($urandom_range(7) == 0) step(1'b1, 16'($urandom), 4'($urandom));
      else                        step(1'b0, '0, '0);
    end
    en_cur = 1'b1;
  endtask

  // Monitor: outputs are present every cycle, sampled 1ns after the rising edge.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        a = pins();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty time=%0t actual=%b required=queued_entry", $time, a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL pins time=%0t actual seg=%b dp=%b an=%b tick=%b pend=%b required seg=%b dp=%b an=%b tick=%b pend=%b",
                     $time, a.seg, a.dp, a.an, a.tick, a.pend, e.seg, e.dp, e.an, e.tick, e.pend);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0; bus.enable = 1'b1;
    en_cur = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset("assert");
    repeat (2) @(negedge clk);
    #1 check_reset("held");

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;
    drive_cycle(1'b0, '0, '0);
    idle(20);

    run_to(6);  step(1'b1, 16'h1234, 4'b0010); idle(2 * FRAME);
    run_to(3);  step(1'b1, 16'hAAAA, 4'b1111);
    run_to(9);  step(1'b1, 16'h00F0, 4'b0000); idle(2 * FRAME);
    run_to(15); step(1'b1, 16'hBEEF, 4'b0101); idle(FRAME + 2);
    run_to(9);  en_cur = 1'b0; idle(3); en_cur = 1'b1; idle(FRAME);
    run_to(5);  step(1'b1, 16'h0070, 4'b1000); idle(2 * FRAME);
    rand_cycles(300);

    run_to(7);
    @(negedge clk);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("midframe");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;
    drive_cycle(1'b0, '0, '0);
    rand_cycles(60);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0 entries", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
